// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_e           : receiver FSM state encodings
//   DATA_BITS            : payload bits per frame
//   BAUD_DIVIDER_DEFAULT : clk cycles per bit period when not overridden
package uart_pkg;

   localparam int DATA_BITS            = 8;
   localparam int BAUD_DIVIDER_DEFAULT = 9;

   typedef enum logic [2:0] {
      RX_IDLE  = 3'd0,
      RX_START = 3'd1,
      RX_DATA  = 3'd2,
      RX_STOP  = 3'd3,
      RX_BREAK = 3'd4
   } rx_state_e;

endpackage

// File: rtl/uart_rx_baud_cnt.sv
// Bit-period timer for the UART receiver.
// Down-counter with a terminal-count compare. load_half arms it for the
// first (half-bit) interval, load_full for a whole bit period; with no load
// it wraps on its own every BAUD_DIVIDER cycles.
// Ports:
//   clk       : reference clock
//   rstn      : synchronous active-low reset
//   load_half : reload with HALF_LOAD (tick HALF_LOAD+1 cycles later)
//   load_full : reload for a full bit period (tick BAUD_DIVIDER cycles later)
//   tick      : high in the cycle the count reaches zero
module uart_rx_baud_cnt #(
   parameter int BAUD_DIVIDER = 9,
   parameter int HALF_LOAD    = 3
) (
   input  logic clk,
   input  logic rstn,
   input  logic load_half,
   input  logic load_full,
   output logic tick
);

   localparam int CW = $clog2(BAUD_DIVIDER);
   localparam logic [CW-1:0] FULL_LOAD_C = CW'(BAUD_DIVIDER - 1);
   localparam logic [CW-1:0] HALF_LOAD_C = CW'(HALF_LOAD);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (load_half) begin
         cnt_d = HALF_LOAD_C;
      end else if (load_full || tick) begin
         cnt_d = FULL_LOAD_C;
      end else begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// Synchronises the Rx pin, finds the start edge, samples each bit at its
// centre and presents the byte with a one-cycle NrD strobe.
// Build option: UART_RX_MAJORITY_EN - each bit decision becomes a 2-of-3 vote
// over centre-1/centre/centre+1 (needs BAUD_DIVIDER >= 6, NrD one cycle later).
// Ports:
//   clk    : reference clock
//   rstn   : synchronous active-low reset
//   Rx     : asynchronous serial input, idle high
//   O_DATA : last correctly framed byte
//   NrD    : one-cycle pulse, new byte on O_DATA
//   RiP    : reception in progress (FSM not idle)
//   FE     : frame error, sticky until next good frame
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | timing to the start-bit centre, rejects glitches
// RX_DATA  | sampling 8 data bits LSB first
// RX_STOP  | timing to the stop-bit centre
// RX_BREAK | stop bit was low, waiting for the line to return high
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUD_DIVIDER = BAUD_DIVIDER_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 Rx,
   output logic [DATA_BITS-1:0] O_DATA,
   output logic                 NrD,
   output logic                 RiP,
   output logic                 FE
);

`ifdef UART_RX_MAJORITY_EN
   // decision moves one cycle later so centre+1 is the live sample
   localparam int VOTE_DELAY = 1;
`else
   localparam int VOTE_DELAY = 0;
`endif
   localparam int HALF_LOAD = BAUD_DIVIDER / 2 - 1 + VOTE_DELAY;

   rx_state_e state_q, state_d;
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic rx_d1_q, rx_d1_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic nrd_q, nrd_d;
   logic fe_q, fe_d;

   logic rx_s;
   logic rx_fall;
   logic bit_val;
   logic tick;
   logic load_half;
   logic load_full;

   assign rx_s    = sync2_q;
   assign rx_fall = rx_d1_q & ~rx_s;

`ifdef UART_RX_MAJORITY_EN
   logic rx_d2_q, rx_d2_d;
   assign rx_d2_d = rx_d1_q;
   assign bit_val = (rx_d2_q & rx_d1_q) | (rx_d2_q & rx_s) | (rx_d1_q & rx_s);
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rx_d2_q <= 1'b1;
      end else begin
         rx_d2_q <= rx_d2_d;
      end
   end
`else
   assign bit_val = rx_s;
`endif

   assign sync1_d = Rx;
   assign sync2_d = sync1_q;
   assign rx_d1_d = rx_s;

   uart_rx_baud_cnt #(
      .BAUD_DIVIDER (BAUD_DIVIDER),
      .HALF_LOAD    (HALF_LOAD)
   ) u_baud_cnt (
      .clk       (clk),
      .rstn      (rstn),
      .load_half (load_half),
      .load_full (load_full),
      .tick      (tick)
   );

   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      nrd_d     = 1'b0;
      fe_d      = fe_q;
      load_half = 1'b0;
      load_full = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (rx_fall) begin
               state_d   = RX_START;
               load_half = 1'b1;
            end
         end
         RX_START: begin
            if (tick) begin
               if (!bit_val) begin
                  state_d   = RX_DATA;
                  bit_idx_d = '0;
                  load_full = 1'b1;
               end else begin
                  state_d = RX_IDLE;
               end
            end
         end
         RX_DATA: begin
            if (tick) begin
               shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               load_full = 1'b1;
               if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                  state_d = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            if (tick) begin
               if (bit_val) begin
                  data_d  = shift_q;
                  nrd_d   = 1'b1;
                  fe_d    = 1'b0;
                  state_d = RX_IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = RX_BREAK;
               end
            end
         end
         RX_BREAK: begin
            // a held-low line must not look like a fresh start bit
            if (rx_s) begin
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= RX_IDLE;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rx_d1_q   <= 1'b1;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         nrd_q     <= 1'b0;
         fe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         rx_d1_q   <= rx_d1_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         nrd_q     <= nrd_d;
         fe_q      <= fe_d;
      end
   end

   assign O_DATA = data_q;
   assign NrD    = nrd_q;
   assign RiP    = (state_q != RX_IDLE);
   assign FE     = fe_q;

endmodule
